// File: rtl/sdp_relu_core_ctrl.sv
// Sequencer and 2-stage valid/ready ReLU pipeline for the SDP X datapath.
// Optional stall counter output perf_stall_cnt is enabled by defining SDP_RELU_CTRL_PERF_EN.
module sdp_relu_core_ctrl #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          op_en,
  input  logic          cfg_relu_bypass,
  input  logic [CW-1:0] cfg_count,
  input  logic          chn_in_pvld,
  output logic          chn_in_prdy,
  input  logic [DW-1:0] chn_in_pd,
  output logic          chn_out_pvld,
  input  logic          chn_out_prdy,
  output logic [DW-1:0] chn_out_pd,
  output logic          core_wen,
  output logic [1:0]    fsm_state,
`ifdef SDP_RELU_CTRL_PERF_EN
  output logic [31:0]   perf_stall_cnt,
`endif
  output logic          op_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cfg_count;
  logic          r_cfg_byp;
  logic [CW-1:0] r_in_cnt;
  logic          r_s1_vld, r_s2_vld;
  logic [DW-1:0] r_s1_pd, r_s2_pd;

  logic          w_s1_adv, w_in_prdy, w_accept, w_start;
  logic [DW-1:0] w_relu;

  assign w_s1_adv  = r_s1_vld && (!r_s2_vld || chn_out_prdy);
  assign w_in_prdy = (r_state == RUN) && (!r_s1_vld || w_s1_adv);
  assign w_accept  = chn_in_pvld && w_in_prdy;
  assign w_start   = (r_state == IDLE) && op_en;
  // Sign bit alone decides the clamp, so the most negative value also maps to 0.
  assign w_relu    = (!r_cfg_byp && chn_in_pd[DW-1]) ? '0 : chn_in_pd;

  assign chn_in_prdy  = w_in_prdy;
  assign core_wen     = w_accept;
  assign chn_out_pvld = r_s2_vld;
  assign chn_out_pd   = r_s2_pd;
  assign fsm_state    = r_state;
  assign op_done      = (r_state == DONE);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state     <= IDLE;
      r_cfg_count <= '0;
      r_cfg_byp   <= 1'b0;
      r_in_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: if (op_en) begin
          r_state     <= RUN;
          r_cfg_count <= cfg_count;
          r_cfg_byp   <= cfg_relu_bypass;
          r_in_cnt    <= '0;
        end
        RUN: if (w_accept) begin
          // Compare before increment: a full-range count wraps only after leaving RUN.
          r_in_cnt <= r_in_cnt + 1'b1;
          if (r_in_cnt == r_cfg_count) r_state <= DRAIN;
        end
        DRAIN: if (!r_s1_vld && !r_s2_vld) r_state <= DONE;
        DONE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s1_vld <= 1'b0;
      r_s1_pd  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_pd  <= '0;
    end else begin
      if (w_accept) begin
        r_s1_vld <= 1'b1;
        r_s1_pd  <= w_relu;
      end else if (w_s1_adv) begin
        r_s1_vld <= 1'b0;
      end
      if (w_s1_adv) begin
        r_s2_vld <= 1'b1;
        r_s2_pd  <= r_s1_pd;
      end else if (chn_out_prdy) begin
        r_s2_vld <= 1'b0;
      end
    end
  end

`ifdef SDP_RELU_CTRL_PERF_EN
  logic [31:0] r_perf;
  logic        w_stall;

  assign w_stall        = ((r_state == RUN) || (r_state == DRAIN)) && r_s2_vld && !chn_out_prdy;
  assign perf_stall_cnt = r_perf;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)               r_perf <= '0;
    else if (w_start)                   r_perf <= '0;
    else if (w_stall && (r_perf != '1)) r_perf <= r_perf + 32'd1;
  end
`endif

endmodule
